ir_key_debouncer: RTL and testbench
===================================

Name: ir_key_debouncer

Overview:
- Parametrised N-channel debouncer and one-shot generator for active-low IR remote / push-button key lines. Successor to the fixed 4-key IDLE/WAIT debouncer.
- Adds: input synchronisers, stable-time qualification on press and release, single-cycle key pulses, an encoded key index, and optional auto-repeat while a key is held.
- Sits between the raw IR decoder key lines and the menu/control FSMs.

Parameters:
- NUM_KEYS, 4, number of key channels (>=1). Index 0 has the highest priority.
- STABLE_CYCLES, 1000, consecutive cycles a level must hold to be accepted (>=2).
- REPEAT_EN, 0, 1 enables auto-repeat while the key is held.
- REPEAT_DELAY, 500000, cycles from the first pulse to the first repeat pulse (>=2).
- REPEAT_PERIOD, 100000, cycles between subsequent repeat pulses (>=2).
- IDX_W, $clog2(NUM_KEYS) (min 1), width of key_idx. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- keys_n  in  NUM_KEYS  raw key lines; active-low; asynchronous to clk.
- deb_n  out  NUM_KEYS  debounced one-shot outputs; active-low; one-cycle low pulse on the accepted key.
- key_valid  out  1  high for exactly the cycle(s) in which deb_n pulses.
- key_idx  out  IDX_W  index of the pulsing key; holds its last value otherwise.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking/reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - deb_n = all 1, key_valid = 0, key_idx = 0, busy = 0.
  - Synchroniser flops = all 1 (released). FSM = IDLE. All counters = 0.
- Synchroniser: two flops per channel. Only the sync'd vector (ks_n) feeds the logic.
- Counters: cnt and rcnt, each sized to hold max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD). They never wrap; they are cleared explicitly.
- All outputs are registered.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE:
  - If any ks_n bit is 0: latch the lowest-index low bit into hold_idx, cnt <= 0, go to DEBOUNCE. Simultaneous presses resolve to the lowest index.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - If ks_n[hold_idx] = 1 (glitch): go to IDLE; no pulse.
  - Else if cnt == STABLE_CYCLES-1: register pulse (deb_n[hold_idx] = 0, key_valid = 1, key_idx = hold_idx), rcnt <= 0, go to HELD.
  - Else cnt++.
  - Other keys changing during DEBOUNCE are ignored.
- HELD:
  - If ks_n[hold_idx] = 1: cnt <= 0, go to RELEASE.
  - Else, when REPEAT_EN=1: rcnt++. At rcnt == REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (later repeats), emit the same one-cycle pulse and set rcnt <= 0. A flag records that the first repeat has occurred.
  - Release and repeat terminal count in the same cycle: release wins, no pulse.
  - Presses of other keys in HELD are ignored, not queued.
- RELEASE:
  - All ks_n bits must be 1 for STABLE_CYCLES consecutive cycles; then go to IDLE.
  - Any 0 bit clears cnt. The state stays RELEASE; the new press is accepted only after a full stable release.
- Latency: press that meets setup before edge E0 → sync valid after E1 → DEBOUNCE entered at E2 → pulse visible after edge E2+STABLE_CYCLES, for one cycle.
- Outside pulse cycles, deb_n = all 1 and key_valid = 0.
- busy = (state != IDLE), registered with the state.
- Reset mid-operation: immediate return to reset values. A pulse in flight is truncated. No pulse follows reset deassertion unless a key is stably pressed again for the full debounce time.

Decomposition:
- Shared package ir_pkg:
  - FSM state enum (IDLE, DEBOUNCE, HELD, RELEASE).
  - Default timing constants for the 50 MHz board (IR_STABLE_CYCLES, IR_REPEAT_DELAY, IR_REPEAT_PERIOD).
  - Key index constants KEY_LEFT=0, KEY_RIGHT=1, KEY_SEL=2, KEY_RST=3.
- One sub-module: ir_sync2 (parametrised-width 2-flop synchroniser, async reset to 1), instantiated once with width NUM_KEYS.

Test Plan:
(all with NUM_KEYS=4, STABLE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=5)
- Clean press: keys_n=4'b1101 held 20 cycles from E0 → exactly one pulse after E6: deb_n=4'b1101, key_valid=1, key_idx=1. busy is high from E2 until 4 cycles after release syncs.
- Glitch: keys_n[0] low for 2 cycles, then high → no pulse. busy returns to 0. FSM back in IDLE.
- Simultaneous press: keys_n 1111→1010 → single pulse with key_idx=0 and deb_n=4'b1110 only.
- Auto-repeat: hold key 2 for 40 cycles after the first pulse at cycle P → repeat pulses at P+10, P+15, P+20, ... with key_idx=2. No pulse after release.
- Release bounce: release key 3, re-press within 2 cycles, then release stably → no second pulse. IDLE is reached only 4 stable-high cycles after the last bounce.
- Reset mid-DEBOUNCE: assert rst asynchronously (between edges) while cnt=2 → outputs and state return to reset values immediately, with no pulse. After deassertion, a held key yields its pulse STABLE_CYCLES cycles after re-entry to DEBOUNCE.

Source files
------------

// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the IR / push-button key debouncer:
//   - FSM state encoding
//   - default timing constants for the 50 MHz board
//   - key channel index constants
//   - small helper used to size the shared counters
// ---------------------------------------------------------------------------
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } ir_state_e;

  // 50 MHz board: 20 us stable time, 10 ms first repeat, 2 ms repeat period
  localparam int IR_STABLE_CYCLES = 1000;
  localparam int IR_REPEAT_DELAY  = 500000;
  localparam int IR_REPEAT_PERIOD = 100000;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_SEL   = 2;
  localparam int KEY_RST   = 3;

  // Largest of three terminal counts; sizes cnt/rcnt so neither can wrap.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/ir_sync2.sv
// ---------------------------------------------------------------------------
// ir_sync2
// Two-flop synchroniser, one chain per bit. Resets to all ones, which is the
// released level of the active-low key lines, so no false press appears while
// the chain refills after reset.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset
//   d    - asynchronous input vector
//   q    - synchronised output vector
// ---------------------------------------------------------------------------
module ir_sync2
  import ir_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability chain: first stage may go metastable, second stage is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= '1;
      sync_r <= '1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/ir_key_debouncer.sv
// ---------------------------------------------------------------------------
// ir_key_debouncer
// N-channel debouncer and one-shot generator for active-low key lines.
// A press must be stable for STABLE_CYCLES before a single-cycle low pulse is
// issued on deb_n; the key must then be released (all lines high) for
// STABLE_CYCLES before a new press is accepted. With REPEAT_EN=1 a held key
// re-pulses after REPEAT_DELAY and then every REPEAT_PERIOD cycles.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   keys_n     - raw active-low key lines (asynchronous to clk)
//   deb_n      - active-low one-cycle pulse on the accepted key
//   key_valid  - high in the pulse cycle
//   key_idx    - index of the pulsing key, holds its last value otherwise
//   busy       - high whenever the FSM is outside IDLE
// ---------------------------------------------------------------------------
module ir_key_debouncer
  import ir_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int STABLE_CYCLES = IR_STABLE_CYCLES,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = IR_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = IR_REPEAT_PERIOD,
  parameter int IDX_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_n,
  output logic [NUM_KEYS-1:0] deb_n,
  output logic                key_valid,
  output logic [IDX_W-1:0]    key_idx,
  output logic                busy
);

  localparam int CNT_MAX = max3(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STABLE_TC     = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_DELAY_TC  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);

  logic [NUM_KEYS-1:0] ks_n_s;

  ir_state_e           state_r,    state_nxt_s;
  logic [CNT_W-1:0]    cnt_r,      cnt_nxt_s;
  logic [CNT_W-1:0]    rcnt_r,     rcnt_nxt_s;
  logic [IDX_W-1:0]    hold_idx_r, hold_idx_nxt_s;
  logic                rep_seen_r, rep_seen_nxt_s;
  logic                pulse_s;

  logic [IDX_W-1:0]    first_low_s;
  logic                any_low_s;
  logic                all_high_s;
  logic                held_rel_s;
  logic [CNT_W-1:0]    rep_tc_s;

  logic [NUM_KEYS-1:0] deb_n_r;
  logic                key_valid_r;
  logic [IDX_W-1:0]    key_idx_r;
  logic                busy_r;

  ir_sync2 #(
    .WIDTH (NUM_KEYS)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (keys_n),
    .q   (ks_n_s)
  );

  // Priority encoder: scanning downward lets the lowest low index win.
  always_comb begin
    first_low_s = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      first_low_s = ks_n_s[i] ? first_low_s : IDX_W'(i);
    end
  end

  assign all_high_s = &ks_n_s;
  assign any_low_s  = ~all_high_s;
  assign held_rel_s = ks_n_s[hold_idx_r];
  // First repeat uses the long delay, later ones the shorter period.
  assign rep_tc_s   = rep_seen_r ? REP_PERIOD_TC : REP_DELAY_TC;

  // Next-state, counter and pulse decode for the key FSM.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    rcnt_nxt_s     = rcnt_r;
    hold_idx_nxt_s = hold_idx_r;
    rep_seen_nxt_s = rep_seen_r;
    pulse_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_low_s) begin
          hold_idx_nxt_s = first_low_s;
          cnt_nxt_s      = '0;
          state_nxt_s    = DEBOUNCE;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      DEBOUNCE: begin
        // Only the latched channel matters; other keys are ignored here.
        if (held_rel_s) begin
          state_nxt_s    = IDLE;
        end else if (cnt_r == STABLE_TC) begin
          pulse_s        = 1'b1;
          rcnt_nxt_s     = '0;
          rep_seen_nxt_s = 1'b0;
          state_nxt_s    = HELD;
        end else begin
          cnt_nxt_s      = cnt_r + CNT_W'(1);
        end
      end
      HELD: begin
        // Release is tested first so it beats a coincident repeat.
        if (held_rel_s) begin
          cnt_nxt_s      = '0;
          state_nxt_s    = RELEASE;
        end else if (REPEAT_EN != 0) begin
          if (rcnt_r == rep_tc_s) begin
            pulse_s        = 1'b1;
            rcnt_nxt_s     = '0;
            rep_seen_nxt_s = 1'b1;
          end else begin
            rcnt_nxt_s     = rcnt_r + CNT_W'(1);
          end
        end else begin
          rcnt_nxt_s     = rcnt_r;
        end
      end
      RELEASE: begin
        // Any low line restarts the release window; no press is queued.
        if (!all_high_s) begin
          cnt_nxt_s      = '0;
        end else if (cnt_r == STABLE_TC) begin
          state_nxt_s    = IDLE;
        end else begin
          cnt_nxt_s      = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        cnt_nxt_s      = '0;
        rcnt_nxt_s     = '0;
        rep_seen_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      rcnt_r     <= '0;
      hold_idx_r <= '0;
      rep_seen_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      rcnt_r     <= rcnt_nxt_s;
      hold_idx_r <= hold_idx_nxt_s;
      rep_seen_r <= rep_seen_nxt_s;
    end
  end

  // Registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_n_r     <= '1;
      key_valid_r <= 1'b0;
      key_idx_r   <= '0;
      busy_r      <= 1'b0;
    end else begin
      deb_n_r     <= pulse_s ? ~(NUM_KEYS'(1) << hold_idx_r) : '1;
      key_valid_r <= pulse_s;
      key_idx_r   <= pulse_s ? hold_idx_r : key_idx_r;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign deb_n     = deb_n_r;
  assign key_valid = key_valid_r;
  assign key_idx   = key_idx_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_ir_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_ir_key_debouncer
// Directed bench for ir_key_debouncer with short timing parameters.
// Expected pulses (cycle, deb_n, key_idx) are queued when a press is driven
// and popped by a negedge monitor whenever the DUT pulses.
// Inputs are driven on the falling edge; a press driven after rising edge k
// produces its first pulse after rising edge k+7 (2 sync + 1 IDLE + 4 stable).
// ---------------------------------------------------------------------------
module tb_ir_key_debouncer;

  localparam int NK  = 4;
  localparam int STB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  typedef struct {
    int         cyc;
    logic [3:0] deb;
    logic [1:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keys_n;
  logic [3:0] deb_n;
  logic       key_valid;
  logic [1:0] key_idx;
  logic       busy;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  ir_key_debouncer #(
    .NUM_KEYS      (NK),
    .STABLE_CYCLES (STB),
    .REPEAT_EN     (1),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys_n    (keys_n),
    .deb_n     (deb_n),
    .key_valid (key_valid),
    .key_idx   (key_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Queue every pulse a press driven at k and released at r must produce.
  // The FSM still sees the key held at edge r+2, so pulses up to r+2 count.
  task automatic push_press(input int k, input int r, input logic [3:0] vec, input logic [1:0] idx);
    int   p;
    bit   first;
    exp_t e;
    p     = k + 3 + STB;
    first = 1'b1;
    while (p <= r + 2) begin
      e.cyc = p;
      e.deb = vec;
      e.idx = idx;
      sb_q.push_back(e);
      p     = p + (first ? RD : RP);
      first = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor: every observed pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (key_valid !== 1'b0 || deb_n !== 4'hF)) begin
      if (sb_q.size() == 0) begin
        check("spurious_deb_n", 32'(deb_n), 32'hF);
        check("spurious_valid", 32'(key_valid), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_deb_n", 32'(deb_n), 32'(e.deb));
        check("pulse_valid", 32'(key_valid), 32'h1);
        check("pulse_idx", 32'(key_idx), 32'(e.idx));
        check("pulse_busy", 32'(busy), 32'h1);
      end
    end
  end

  initial begin
    int k;
    int r;
    int m;
    rst    = 1'b1;
    keys_n = 4'hF;
    step(3);
    check("rst_deb_n", 32'(deb_n), 32'hF);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_idx", 32'(key_idx), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step(3);

    // Clean press of key 1
    k = cyc;
    keys_n = 4'b1101;
    push_press(k, k + 8, 4'b1101, 2'd1);
    step(2);
    check("clean_busy_pre", 32'(busy), 32'h0);
    step(1);
    check("clean_busy_on", 32'(busy), 32'h1);
    step(5);
    r = cyc;
    keys_n = 4'hF;
    step(6);
    check("clean_busy_hold", 32'(busy), 32'h1);
    step(1);
    check("clean_busy_off", 32'(busy), 32'h0);
    step(3);

    // Glitch on key 0: two low cycles, no pulse
    k = cyc;
    keys_n = 4'b1110;
    step(2);
    keys_n = 4'hF;
    step(2);
    check("glitch_busy_deb", 32'(busy), 32'h1);
    step(1);
    check("glitch_busy_off", 32'(busy), 32'h0);
    step(5);
    check("glitch_sb_empty", 32'(sb_q.size()), 32'h0);

    // Simultaneous press of keys 0 and 2: key 0 wins
    k = cyc;
    keys_n = 4'b1010;
    push_press(k, k + 8, 4'b1110, 2'd0);
    step(8);
    keys_n = 4'hF;
    step(12);

    // Auto-repeat on key 2, released 40 cycles after the first pulse
    k = cyc;
    keys_n = 4'b1011;
    push_press(k, k + 47, 4'b1011, 2'd2);
    step(47);
    keys_n = 4'hF;
    step(12);
    check("repeat_sb_empty", 32'(sb_q.size()), 32'h0);

    // Release bounce on key 3
    k = cyc;
    keys_n = 4'b0111;
    push_press(k, k + 8, 4'b0111, 2'd3);
    step(8);
    r = cyc;
    keys_n = 4'hF;
    step(1);
    keys_n = 4'b0111;
    step(1);
    keys_n = 4'hF;
    step(5);
    check("bounce_busy_hold", 32'(busy), 32'h1);
    step(1);
    check("bounce_busy_off", 32'(busy), 32'h0);
    step(3);

    // Asynchronous reset while cnt=2 in DEBOUNCE
    k = cyc;
    keys_n = 4'b1101;
    step(5);
    #2 rst = 1'b1;
    #1;
    check("arst_deb_n", 32'(deb_n), 32'hF);
    check("arst_valid", 32'(key_valid), 32'h0);
    check("arst_idx", 32'(key_idx), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    step(2);
    rst = 1'b0;
    m = cyc;
    push_press(m, m + 8, 4'b1101, 2'd1);
    step(8);
    keys_n = 4'hF;
    step(12);

    check("final_sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
